// File: rtl/ysyx_22040729_mem_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
// Optional build macro: YSYX_22040729_MEM_ARB_RR_EN (round-robin arbitration).
package ysyx_22040729_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Values double as bit positions in the request/grant vectors
  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  localparam int DW_DEF = 64;
  localparam int MW = DW_DEF / 8;
  localparam logic [MW-1:0] FULL_MASK = {MW{1'b1}};

endpackage

// File: rtl/ysyx_22040729_arb2.sv
// Two-way arbiter with one-hot grant; fixed LSU-first priority by default,
// round-robin with a last-grant register under YSYX_22040729_MEM_ARB_RR_EN.
module ysyx_22040729_arb2
  import ysyx_22040729_mem_pkg::*;
(
`ifdef YSYX_22040729_MEM_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       i_hs,
`endif
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

`ifdef YSYX_22040729_MEM_ARB_RR_EN
  logic r_last_lsu;

  // Starts as if the LSU won last, so the IFU takes the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_lsu <= 1'b1;
    end else if (i_hs) begin
      r_last_lsu <= o_gnt[REQ_LSU];
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    if (&i_req) begin
      if (r_last_lsu) o_gnt[REQ_IFU] = 1'b1;
      else            o_gnt[REQ_LSU] = 1'b1;
    end else begin
      o_gnt = i_req;
    end
  end
`else
  always_comb begin
    o_gnt = 2'b00;
    if (i_req[REQ_LSU])      o_gnt[REQ_LSU] = 1'b1;
    else if (i_req[REQ_IFU]) o_gnt[REQ_IFU] = 1'b1;
  end
`endif

endmodule

// File: rtl/ysyx_22040729_mem_arbiter.sv
// Shares one single-port memory between IFU and LSU; masked stores become RMW.
// Optional build macro: YSYX_22040729_MEM_ARB_RR_EN (round-robin arbitration).
module ysyx_22040729_mem_arbiter
  import ysyx_22040729_mem_pkg::*;
#(
  parameter int DATA_DEPTH = 65536,
  parameter int ADDR_WIDTH = $clog2(DATA_DEPTH),
  parameter int INST_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_rsp_valid,
  output logic [INST_WIDTH-1:0]   ifu_rdata,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic                    lsu_wen,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
  output logic                    lsu_rsp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_rdata,
  output logic                    mem_wen,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int LMW = DATA_WIDTH / 8;

  state_e                r_state;
  req_id_e               r_owner;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wen;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [LMW-1:0]        r_wmask;

  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic                  w_idle;
  logic                  w_ifu_hs;
  logic                  w_lsu_hs;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_merge;

  assign w_req = {lsu_req_valid, ifu_req_valid};

  ysyx_22040729_arb2 u_arb (
`ifdef YSYX_22040729_MEM_ARB_RR_EN
    .clk   (clk),
    .rst   (rst),
    .i_hs  (w_ifu_hs | w_lsu_hs),
`endif
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign w_idle        = (r_state == IDLE) && !rst;
  assign ifu_req_ready = w_idle & w_gnt[REQ_IFU];
  assign lsu_req_ready = w_idle & w_gnt[REQ_LSU];
  assign w_ifu_hs      = ifu_req_valid & ifu_req_ready;
  assign w_lsu_hs      = lsu_req_valid & lsu_req_ready;
  assign w_full        = &r_wmask;

  for (genvar g = 0; g < LMW; g++) begin : g_merge
    assign w_merge[8*g +: 8] = r_wmask[g] ? r_wdata[8*g +: 8]
                                          : mem_rdata[8*g +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= REQ_IFU;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_lsu_hs) begin
            r_owner <= REQ_LSU;
            r_addr  <= lsu_addr;
            r_wen   <= lsu_wen;
            r_wdata <= lsu_wdata;
            r_wmask <= lsu_wmask;
            r_state <= ACCESS;
          end else if (w_ifu_hs) begin
            r_owner <= REQ_IFU;
            r_addr  <= ifu_addr;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_state <= ACCESS;
          end
        end
        ACCESS:  r_state <= (r_wen && !w_full) ? MERGE : DONE;
        MERGE:   r_state <= DONE;
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_wen       = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    ifu_rsp_valid = 1'b0;
    ifu_rdata     = '0;
    lsu_rsp_valid = 1'b0;
    lsu_rdata     = '0;
    unique case (r_state)
      ACCESS: begin
        mem_addr = r_addr;
        if (r_wen && w_full) begin
          mem_wen   = 1'b1;
          mem_wdata = r_wdata;
        end
      end
      MERGE: begin
        mem_wen   = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = w_merge;
      end
      DONE: begin
        // Read data arrives now from the address issued in ACCESS
        if (r_owner == REQ_LSU) begin
          lsu_rsp_valid = 1'b1;
          if (!r_wen) lsu_rdata = mem_rdata;
        end else begin
          ifu_rsp_valid = 1'b1;
          ifu_rdata     = mem_rdata[INST_WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22040729_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter with a byte-array memory model.
// Covers YSYX_22040729_MEM_ARB_RR_EN when that macro is defined.
module tb_ysyx_22040729_mem_arbiter;
  import ysyx_22040729_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [15:0] ifu_addr = '0;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic        lsu_wen = 1'b0;
  logic [15:0] lsu_addr = '0;
  logic [63:0] lsu_wdata = '0;
  logic [7:0]  lsu_wmask = '0;
  logic        lsu_rsp_valid;
  logic [63:0] lsu_rdata;
  logic        mem_wen;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;

  logic [7:0]  mem [0:65535];

  int n_chk = 0;
  int n_pass = 0;

  ysyx_22040729_mem_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_wen       (lsu_wen),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rdata     (lsu_rdata),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory: 1-cycle read, full-width write, little-endian bytes
  always @(posedge clk) begin
    if (rst) begin
      mem[16'h0100] <= 8'h13;
      mem[16'h0101] <= 8'h05;
      mem[16'h0102] <= 8'h00;
      mem[16'h0103] <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (mem_wen) mem[16'(mem_addr + 16'(i))] <= mem_wdata[8*i +: 8];
        mem_rdata[8*i +: 8] <= mem[16'(mem_addr + 16'(i))];
      end
    end
  end

  function automatic logic [63:0] peek(input logic [15:0] a);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = mem[16'(a + 16'(i))];
    return d;
  endfunction

  task automatic do_lsu(input logic wen, input logic [15:0] a,
                        input logic [63:0] wd, input logic [7:0] m,
                        output int lat, output logic [63:0] rd);
    int k;
    @(negedge clk);
    lsu_req_valid = 1'b1;
    lsu_wen = wen;
    lsu_addr = a;
    lsu_wdata = wd;
    lsu_wmask = m;
    #1;
    k = 0;
    while (!lsu_req_ready && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    @(negedge clk);
    lsu_req_valid = 1'b0;
    lsu_wdata = '0;
    lsu_addr = '0;
    lsu_wmask = '0;
    #1;
    lat = 1;
    while (!lsu_rsp_valid && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    rd = lsu_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b00)
      $display("FAIL reset_ready: got %b want 00", {ifu_req_ready, lsu_req_ready});
    else n_pass++;
    n_chk++;
    if ({mem_wen, ifu_rsp_valid, lsu_rsp_valid} !== 3'b000)
      $display("FAIL reset_ctl: got %b want 000", {mem_wen, ifu_rsp_valid, lsu_rsp_valid});
    else n_pass++;
    n_chk++;
    if ({ifu_rdata, lsu_rdata} !== 96'h0)
      $display("FAIL reset_rdata: got %h want 0", {ifu_rdata, lsu_rdata});
    else n_pass++;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    ifu_req_valid = 1'b1;
    ifu_addr = 16'h0100;
    #1;
    n_chk++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10)
      $display("FAIL fetch_ready: got %b want 10", {ifu_req_ready, lsu_req_ready});
    else n_pass++;
    @(negedge clk);
    ifu_req_valid = 1'b0;
    ifu_addr = 16'h0000;
    #1;
    n_chk++;
    if ({ifu_req_ready, mem_wen, mem_addr} !== {2'b00, 16'h0100})
      $display("FAIL fetch_access: got %b %h want 00 0100",
               {ifu_req_ready, mem_wen}, mem_addr);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifu_rsp_valid, ifu_rdata} !== {1'b1, 32'h00000513})
      $display("FAIL fetch_rsp: got %b %h want 1 00000513", ifu_rsp_valid, ifu_rdata);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifu_rsp_valid, ifu_rdata} !== 33'h0)
      $display("FAIL fetch_pulse: got %b %h want 0 0", ifu_rsp_valid, ifu_rdata);
    else n_pass++;
  endtask

  task automatic test_full_store();
    int lat;
    logic [63:0] rd;
    @(negedge clk);
    lsu_req_valid = 1'b1;
    lsu_wen = 1'b1;
    lsu_addr = 16'h0200;
    lsu_wdata = 64'h1122334455667788;
    lsu_wmask = FULL_MASK;
    #1;
    n_chk++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01)
      $display("FAIL fst_ready: got %b want 01", {ifu_req_ready, lsu_req_ready});
    else n_pass++;
    @(negedge clk);
    lsu_req_valid = 1'b0;
    lsu_wdata = '0;
    #1;
    n_chk++;
    if ({mem_wen, mem_addr, mem_wdata} !== {1'b1, 16'h0200, 64'h1122334455667788})
      $display("FAIL fst_write: got %b %h %h want 1 0200 1122334455667788",
               mem_wen, mem_addr, mem_wdata);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if ({lsu_rsp_valid, lsu_rdata, mem_wen} !== {1'b1, 64'h0, 1'b0})
      $display("FAIL fst_ack: got %b %h %b want 1 0 0", lsu_rsp_valid, lsu_rdata, mem_wen);
    else n_pass++;
    do_lsu(1'b0, 16'h0200, 64'h0, 8'h00, lat, rd);
    n_chk++;
    if ({lat, rd} !== {32'd2, 64'h1122334455667788})
      $display("FAIL fst_load: got lat %0d %h want lat 2 1122334455667788", lat, rd);
    else n_pass++;
  endtask

  task automatic test_partial_store();
    int lat;
    logic [63:0] rd;
    @(negedge clk);
    lsu_req_valid = 1'b1;
    lsu_wen = 1'b1;
    lsu_addr = 16'h0200;
    lsu_wdata = 64'hAAAAAAAAAAAAAAAA;
    lsu_wmask = 8'h0F;
    @(negedge clk);
    lsu_req_valid = 1'b0;
    lsu_wdata = '0;
    lsu_wmask = '0;
    #1;
    n_chk++;
    if ({mem_wen, mem_addr} !== {1'b0, 16'h0200})
      $display("FAIL pst_read: got %b %h want 0 0200", mem_wen, mem_addr);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if ({mem_wen, mem_wdata, lsu_rsp_valid} !== {1'b1, 64'h11223344AAAAAAAA, 1'b0})
      $display("FAIL pst_merge: got %b %h %b want 1 11223344AAAAAAAA 0",
               mem_wen, mem_wdata, lsu_rsp_valid);
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if ({lsu_rsp_valid, mem_wen} !== 2'b10)
      $display("FAIL pst_ack: got %b want 10", {lsu_rsp_valid, mem_wen});
    else n_pass++;
    do_lsu(1'b0, 16'h0200, 64'h0, 8'h00, lat, rd);
    n_chk++;
    if (rd !== 64'h11223344AAAAAAAA)
      $display("FAIL pst_load: got %h want 11223344AAAAAAAA", rd);
    else n_pass++;
  endtask

  task automatic test_mask_zero();
    int lat;
    logic [63:0] rd;
    do_lsu(1'b1, 16'h0200, 64'hFFFFFFFFFFFFFFFF, 8'h00, lat, rd);
    n_chk++;
    if ({lat, rd} !== {32'd3, 64'h0})
      $display("FAIL m0_ack: got lat %0d %h want lat 3 0", lat, rd);
    else n_pass++;
    n_chk++;
    if (peek(16'h0200) !== 64'h11223344AAAAAAAA)
      $display("FAIL m0_mem: got %h want 11223344AAAAAAAA", peek(16'h0200));
    else n_pass++;
  endtask

  task automatic test_both_valid();
    logic first_lsu;
`ifdef YSYX_22040729_MEM_ARB_RR_EN
    first_lsu = 1'b0;
`else
    first_lsu = 1'b1;
`endif
    @(negedge clk);
    ifu_req_valid = 1'b1;
    ifu_addr = 16'h0100;
    lsu_req_valid = 1'b1;
    lsu_wen = 1'b0;
    lsu_addr = 16'h0200;
    #1;
    n_chk++;
    if ({lsu_req_ready, ifu_req_ready} !== {first_lsu, !first_lsu})
      $display("FAIL both_grant1: got lsu/ifu %b want %b",
               {lsu_req_ready, ifu_req_ready}, {first_lsu, !first_lsu});
    else n_pass++;
    @(negedge clk);
    if (first_lsu) lsu_req_valid = 1'b0;
    else ifu_req_valid = 1'b0;
    #1;
    n_chk++;
    if ({lsu_req_ready, ifu_req_ready} !== 2'b00)
      $display("FAIL both_busy: got %b want 00", {lsu_req_ready, ifu_req_ready});
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if ({lsu_rsp_valid, ifu_rsp_valid} !== {first_lsu, !first_lsu})
      $display("FAIL both_rsp1: got lsu/ifu %b want %b",
               {lsu_rsp_valid, ifu_rsp_valid}, {first_lsu, !first_lsu});
    else n_pass++;
    @(negedge clk);
    #1;
    n_chk++;
    if ({lsu_req_ready, ifu_req_ready} !== {!first_lsu, first_lsu})
      $display("FAIL both_grant2: got lsu/ifu %b want %b",
               {lsu_req_ready, ifu_req_ready}, {!first_lsu, first_lsu});
    else n_pass++;
    @(negedge clk);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    @(negedge clk);
    #1;
    n_chk++;
    if ({ifu_rsp_valid, ifu_rdata, lsu_rsp_valid, lsu_rdata} !==
        (first_lsu ? {1'b1, 32'h00000513, 1'b0, 64'h0}
                   : {1'b0, 32'h0, 1'b1, 64'h11223344AAAAAAAA}))
      $display("FAIL both_rsp2: got ifu %b %h lsu %b %h first_lsu %b",
               ifu_rsp_valid, ifu_rdata, lsu_rsp_valid, lsu_rdata, first_lsu);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [63:0] rd;
    @(negedge clk);
    lsu_req_valid = 1'b1;
    lsu_wen = 1'b1;
    lsu_addr = 16'h0200;
    lsu_wdata = 64'h5555555555555555;
    lsu_wmask = 8'hF0;
    @(negedge clk);
    lsu_req_valid = 1'b0;
    @(negedge clk);
    #1;
    n_chk++;
    if (mem_wen !== 1'b1)
      $display("FAIL rm_in_merge: got mem_wen %b want 1", mem_wen);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++;
    if ({mem_wen, lsu_req_ready} !== 2'b00)
      $display("FAIL rm_async: got %b want 00", {mem_wen, lsu_req_ready});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if ({lsu_rsp_valid, lsu_req_ready} !== 2'b00)
      $display("FAIL rm_no_rsp: got %b want 00", {lsu_rsp_valid, lsu_req_ready});
    else n_pass++;
    n_chk++;
    if (peek(16'h0200) !== 64'h11223344AAAAAAAA)
      $display("FAIL rm_mem: got %h want 11223344AAAAAAAA", peek(16'h0200));
    else n_pass++;
    do_lsu(1'b0, 16'h0200, 64'h0, 8'h00, lat, rd);
    n_chk++;
    if ({lat, rd} !== {32'd2, 64'h11223344AAAAAAAA})
      $display("FAIL rm_load: got lat %0d %h want lat 2 11223344AAAAAAAA", lat, rd);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_full_store();
    test_partial_store();
    test_mask_zero();
    test_both_valid();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_22040729_mem_arbiter.md
Name: ysyx_22040729_mem_arbiter

Overview:
Shares the single-port byte-addressed unified memory between the IFU (instruction fetch) and the LSU (load/store).
- Arbitrates between the two requesters and sequences each access with 1-cycle synchronous read latency.
- The memory exposes only a full-width write enable, so byte-masked LSU stores are converted into read-modify-write.
- Sits between the IFU/LSU and the memory instance.

Parameters:
DATA_DEPTH, 65536, memory depth in bytes
ADDR_WIDTH, $clog2(DATA_DEPTH), byte address width
INST_WIDTH, 32, IFU response width
DATA_WIDTH, 64, LSU/memory data width; mask width MW = DATA_WIDTH/8

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous active-high reset
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_WIDTH  fetch byte address
ifu_rsp_valid  out  1  fetch data valid (one-cycle pulse)
ifu_rdata  out  INST_WIDTH  instruction = mem_rdata[INST_WIDTH-1:0]
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_wen  in  1  1 = store, 0 = load
lsu_addr  in  ADDR_WIDTH  byte address
lsu_wdata  in  DATA_WIDTH  store data
lsu_wmask  in  MW  byte enables for store
lsu_rsp_valid  out  1  load data valid or store acknowledge (pulse)
lsu_rdata  out  DATA_WIDTH  load data
mem_wen  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after address

Behaviour:
- State machine: IDLE, ACCESS, MERGE, DONE.
- Reset:
  - State = IDLE; grant pointer and latched request cleared.
  - While rst is high: all ready, rsp_valid and mem_wen = 0; all rdata = 0.
- IDLE:
  - ready is asserted combinationally to the arbitration winner only.
  - On handshake (valid & ready) the arbiter latches requester ID, addr, wen, wdata and wmask, then moves to ACCESS.
  - Requester inputs may change after the handshake.
- Arbitration: fixed priority, LSU > IFU, when both are valid in the same IDLE cycle.
- ready = 0 in all states other than IDLE. A requester's valid held during a busy period is served on a later IDLE cycle.
- ACCESS:
  - mem_addr = latched address.
  - Full store (wen & wmask == all ones): mem_wen = 1, mem_wdata = wdata, next state DONE.
  - Partial store (wen & wmask != all ones, including 0): mem_wen = 0 (read), next state MERGE.
  - Load or fetch: mem_wen = 0, next state DONE.
- MERGE:
  - mem_wen = 1, mem_addr = latched address.
  - mem_wdata byte i = wmask[i] ? wdata byte i : mem_rdata byte i.
  - Mask 0 rewrites unchanged data.
  - Next state DONE.
- DONE:
  - The owner's rsp_valid = 1 for exactly one cycle; next state IDLE.
  - Read data passes through from mem_rdata; reads in DONE are issued from ACCESS.
  - For a store, lsu_rdata = 0 and the rsp is an acknowledge only.
- rdata outputs are 0 whenever their rsp_valid = 0.
- mem_addr = 0 and mem_wen = 0 in IDLE and DONE.
- Latency, with handshake in cycle T:
  - Load, fetch or full store: rsp in T+2.
  - Partial store: rsp in T+3.
- Minimum request spacing is 3 cycles; 4 cycles for a partial store.
- No alignment checks. The address is passed through unchanged; byte-lane addressing is the memory's job.
- Reset mid-operation: return to IDLE immediately, no rsp is issued, mem_wen drops asynchronously. A partial store aborted before MERGE leaves memory unchanged.

Optional Feature:
YSYX_22040729_MEM_ARB_RR_EN
- Defined: round-robin arbitration. A 1-bit last-grant register is updated on each handshake; the requester not last granted wins ties. Reset value = LSU last granted, so the IFU wins the first tie.
- Undefined: fixed priority LSU > IFU; no last-grant register.

Decomposition:
- Package ysyx_22040729_mem_pkg holds:
  - State enum {IDLE, ACCESS, MERGE, DONE}.
  - Requester-ID typedef {REQ_IFU, REQ_LSU}.
  - Constant MW and the full-mask constant.
- Sub-module ysyx_22040729_arb2: 2-way arbiter producing a one-hot grant. It contains the macro-selected fixed/round-robin logic and the last-grant register.

Test Plan:
- IFU fetch addr 0x100, memory bytes 0x100..0x103 = 13 05 00 00 -> ifu_req_ready in T, ifu_rsp_valid in T+2, ifu_rdata = 0x00000513.
- LSU full store addr 0x200, wdata 0x1122334455667788, mask 0xFF -> mem_wen in T+1, ack in T+2; a following load returns 0x1122334455667788.
- Partial store to 0x200, wdata 0xAAAAAAAAAAAAAAAA, mask 0x0F -> read in T+1, write in T+2, ack in T+3; load returns 0x11223344AAAAAAAA.
- Both requesters valid in the same cycle:
  - Without macro: LSU served first, IFU handshakes on the next IDLE cycle, rsp 3 cycles later.
  - With macro: IFU first, then alternating grants.
- rst asserted in MERGE of a partial store -> mem_wen drops immediately, no lsu_rsp_valid, memory at 0x200 unchanged, state returns to IDLE.
- Mask 0x00 store -> RMW performed, ack in T+3, memory unchanged.
